// File: rtl/gshare_predictor.sv
// gshare direction predictor: 2-bit counter PHT indexed by PC ^ speculative GHR.
// Ports:
//   clock, reset: rising-edge clock, synchronous active-high reset.
//   lookup_valid, lookup_pc: fetch-side query.
//   predict_taken, predict_ghr: combinational answer plus the history snapshot used.
//   update_valid, update_pc, update_ghr, update_taken, update_mispredict: resolved-branch training.
module gshare_predictor #(
  parameter int PHT_ENTRIES = 64,
  parameter int GHR_BITS    = 6,
  localparam int IDX_BITS   = $clog2(PHT_ENTRIES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                predict_taken,
  output logic [GHR_BITS-1:0] predict_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [GHR_BITS-1:0] update_ghr,
  input  logic                update_taken,
  input  logic                update_mispredict
);

  logic [1:0]          pht_q [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;
  logic [IDX_BITS-1:0] lidx;
  logic [IDX_BITS-1:0] uidx;
  logic [1:0]          cnt_q_u;
  logic [1:0]          cnt_d;

  // One extra bit so the shift also works for a 1-bit history.
  logic [GHR_BITS:0]   spec_shift;
  logic [GHR_BITS:0]   repair_shift;

  logic unused_pc_bits;

  assign lidx = lookup_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
  assign uidx = update_pc[IDX_BITS+1:2] ^ IDX_BITS'(update_ghr);

  assign predict_taken = pht_q[lidx][1];
  assign predict_ghr   = ghr_q;

  assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                            update_pc[31:IDX_BITS+2], update_pc[1:0],
                            spec_shift[GHR_BITS], repair_shift[GHR_BITS]};

  assign cnt_q_u = pht_q[uidx];

  always_comb begin
    cnt_d = cnt_q_u;
    if (update_taken) begin
      if (cnt_q_u != 2'd3) cnt_d = cnt_q_u + 2'd1;
    end else begin
      if (cnt_q_u != 2'd0) cnt_d = cnt_q_u - 2'd1;
    end
  end

  assign spec_shift   = {ghr_q, predict_taken};
  assign repair_shift = {update_ghr, update_taken};

  // Mispredict repair overrides the speculative shift of a same-cycle lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = repair_shift[GHR_BITS-1:0];
    end else if (lookup_valid) begin
      ghr_d = spec_shift[GHR_BITS-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= 2'b01;
      end
      ghr_q <= '0;
    end else begin
      if (update_valid) pht_q[uidx] <= cnt_d;
      ghr_q <= ghr_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios with literal
// expectations, then randomized traffic against an arithmetic reference model.
module tb_gshare_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [5:0]  predict_ghr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [5:0]  update_ghr;
  logic        update_taken;
  logic        update_mispredict;

  int pht [64];
  int ghr;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  gshare_predictor #(.PHT_ENTRIES(64), .GHR_BITS(6)) dut (
    .clock             (clock),
    .reset             (reset),
    .lookup_valid      (lookup_valid),
    .lookup_pc         (lookup_pc),
    .predict_taken     (predict_taken),
    .predict_ghr       (predict_ghr),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_ghr        (update_ghr),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) pht[i] = 1;
    ghr = 0;
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input bit r, input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input int ughr,
                      input bit ut, input bit um,
                      input int et = -1, input int eg = -1);
    int mi;
    int ui;
    int mt;
    reset             = r;
    lookup_valid      = lv;
    lookup_pc         = lpc;
    update_valid      = uv;
    update_pc         = upc;
    update_ghr        = ughr[5:0];
    update_taken      = ut;
    update_mispredict = um;
    mi = int'((lpc >> 2) % 64) ^ ghr;
    mt = (pht[mi] >= 2) ? 1 : 0;
    @(negedge clock);
    if (!r) begin
      chk("predict_ghr", int'(predict_ghr), ghr);
      if (lv) chk("predict_taken", int'(predict_taken), mt);
    end
    if (et >= 0) chk("lit_taken", int'(predict_taken), et);
    if (eg >= 0) chk("lit_ghr", int'(predict_ghr), eg);
    @(posedge clock);
    #1;
    if (r) begin
      model_reset();
    end else begin
      if (uv) begin
        ui = int'((upc >> 2) % 64) ^ ughr;
        if (ut) pht[ui] = (pht[ui] + 1 > 3) ? 3 : pht[ui] + 1;
        else    pht[ui] = (pht[ui] - 1 < 0) ? 0 : pht[ui] - 1;
      end
      if (uv && um)  ghr = (ughr * 2 + int'(ut)) % 64;
      else if (lv)   ghr = (ghr * 2 + mt) % 64;
    end
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 32'h100, 0, 0, 0, 0, 0, -1, 0);

    // Training to saturation at index 0x10
    repeat (4) step(0, 0, 0, 1, 32'h40, 0, 1, 0);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 1, 0);

    // Speculative history: ghr 1 then 2
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1, 4);

    // Repair ghr to 1, then alias pc 0x44 onto index 0x10
    step(0, 0, 0, 1, 32'h40, 0, 1, 1);
    step(0, 1, 32'h44, 0, 0, 0, 0, 0, 1, 1);

    // Train down to 0 and saturate; view it with ghr repaired to 0
    repeat (5) step(0, 0, 0, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 1, 32'h0, 6'b100000, 0, 1);
    step(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);

    // Mispredict ignored when update_valid is low
    step(0, 0, 0, 0, 32'h0, 6'b111111, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Mispredict repair beats same-cycle lookup shift
    step(0, 0, 0, 1, 32'h200, 6'b010101, 1, 1);
    step(0, 1, 32'h40, 1, 32'h300, 6'b000111, 0, 1, -1, 6'b101011);
    step(0, 0, 0, 0, 0, 0, 0, 0, -1, 6'b001110);

    // Same-index collision at index 5 (read-before-write)
    step(0, 1, 32'h2C, 1, 32'h14, 0, 1, 0, 0, 6'b001110);
    step(0, 1, 32'h64, 0, 0, 0, 0, 0, 1, 6'b011100);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit r;
      int ug;
      r  = ($urandom_range(199) == 0);
      ug = $urandom_range(1) ? ghr : int'($urandom_range(63));
      step(r, 1'($urandom), $urandom, 1'($urandom), $urandom, ug,
           1'($urandom), ($urandom_range(3) == 0));
    end

    // Reset mid-operation wipes training and history
    step(1, 1, 32'h40, 1, 32'h40, 0, 1, 1);
    step(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Direction predictor for the fetch stage. It holds a pattern history table (PHT) of 2-bit saturating counters indexed by PC XOR a speculative global history register (GHR). Fetch gets a combinational taken/not-taken prediction plus a history snapshot. Execute/retire returns resolved outcomes that train the counters and, on a mispredict, repair the GHR.

## Interface
- `PHT_ENTRIES`, default 64: number of counters; must be a power of two. `IDX_BITS = $clog2(PHT_ENTRIES)`.
- `GHR_BITS`, default 6: global history length; 1 ≤ `GHR_BITS` ≤ `IDX_BITS`.
- `clock`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: reset, synchronous, active-high.
- `lookup_valid`  in  1: fetch is predicting a conditional branch this cycle.
- `lookup_pc`  in  32: PC of the branch being predicted.
- `predict_taken`  out  1: prediction for `lookup_pc`; valid whenever `lookup_valid` is high.
- `predict_ghr`  out  `GHR_BITS`: GHR value used for this lookup (before the shift); travels with the branch down the pipe.
- `update_valid`  in  1: a resolved conditional branch is returned this cycle.
- `update_pc`  in  32: PC of the resolved branch.
- `update_ghr`  in  `GHR_BITS`: the `predict_ghr` snapshot carried by that branch.
- `update_taken`  in  1: actual direction.
- `update_mispredict`  in  1: the prediction was wrong; qualified by `update_valid`.

## Operation
- Lookup index: `lidx = lookup_pc[IDX_BITS+1:2] ^ {{(IDX_BITS-GHR_BITS){1'b0}}, ghr}`.
- Update index: `uidx = update_pc[IDX_BITS+1:2] ^ zero-extended update_ghr`.
- `predict_taken = pht[lidx][1]`, i.e. counter value 2 or 3 predicts taken.
- `predict_ghr = ghr` (current register value).
- Counter training when `update_valid` is high:
  - Taken: `pht[uidx] = min(pht[uidx]+1, 3)`.
  - Not taken: `pht[uidx] = max(pht[uidx]-1, 0)`.
  - Saturation at 3 and 0 is mandatory; no wrap-around.
- GHR update, in priority order:
  1. If `update_valid && update_mispredict`: `ghr <= {update_ghr[GHR_BITS-2:0], update_taken}`. This repairs speculative history, and any same-cycle lookup shift is discarded.
  2. Else if `lookup_valid`: `ghr <= {ghr[GHR_BITS-2:0], predict_taken}`.
  3. Else hold.
  - With `GHR_BITS == 1`, the shifted value is just the new bit.
- Counter training is independent of the GHR update. Both happen in the same cycle when both inputs are valid.
- Reset: every PHT counter = 2'b01 (weakly not-taken), `ghr = 0`.
  - Outputs after reset: `predict_taken = 0`, `predict_ghr = 0`.
  - Reset asserted mid-operation discards all training and history on that edge.

## Timing
- Prediction is combinational: same cycle as `lookup_valid`/`lookup_pc`, zero latency.
- Training and GHR updates become visible one cycle after the update/lookup edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update counter (read-before-write). The new value is visible from the next cycle.
- No backpressure and no handshake. One lookup and one update are accepted every cycle, unconditionally.
- `update_mispredict` is ignored when `update_valid` is low.
- `lookup_pc`/`update_pc` bits [1:0] and bits above `IDX_BITS+1` do not affect indexing.

## Test plan
All scenarios use the defaults (`PHT_ENTRIES=64`, `GHR_BITS=6`).
- **Reset state:** after reset, lookup at `pc=0x100` -> `predict_taken=0`, `predict_ghr=0`. Next cycle `ghr=6'b000000` (shifted 0).
- **Training and saturation:** with history held at 0 (lookup_valid low), apply updates on `pc=0x40`, `update_ghr=0`, taken ×4 -> counter goes 1→2→3→3→3. Lookup then predicts taken. Not-taken ×5 -> counter reaches 0 and stays; lookup predicts not-taken.
- **Speculative history:** starting from `ghr=0`, with counter at index 0x10 trained to 3, perform 3 consecutive lookups.
  - Lookup at `pc=0x40` -> predicts taken; `ghr` becomes 6'b000001.
  - `predict_ghr` sequence must be 0, 1, then the next shifted values.
- **Mispredict repair:** with `ghr=6'b101011`, assert update with mispredict, `update_ghr=6'b000111`, `update_taken=0`, together with a `lookup_valid` -> next cycle `ghr=6'b001110`; the lookup shift is dropped.
- **Aliasing via XOR:** `pc=0x44` with `ghr=6'b000001` and `pc=0x40` with `ghr=0` both map to index 0x10. Training through one must change the prediction seen by the other.
- **Same-index collision:** in one cycle, lookup and taken-update both hit index 5 whose counter is 1 -> that cycle predicts not-taken; the following cycle's lookup predicts taken.
